// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle base ops plus iterative RV32M multiply/divide.
// Optional macro ALU_MC_EARLY_OUT_EN resolves trivial MUL/DIV operands on the accept edge.
module alu_mc #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_a_i,
  input  logic [XLEN-1:0] alu_b_i,
  input  logic            flush_i,
  output logic            alu_busy_o,
  output logic            alu_result_valid_o,
  output logic [XLEN-1:0] alu_result_o
);

  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   hi_r, lo_r, opb_r, result_r;
  logic [4:0]        op_r;
  logic              neg_res_r, neg_rem_r, div0_r, valid_r;

  logic              accept_s, is_mul_s, is_div_s, a_sgn_s, b_sgn_s, early_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, quick_s, early_res_s, fin_s;
  logic [XLEN-1:0]   mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s;
  logic [SHAMT_W-1:0] shamt_s;

  assign accept_s = alu_valid_i && (state_r == S_IDLE) && !flush_i;
  assign is_mul_s = (alu_op_i[4:2] == 3'b100);
  assign is_div_s = (alu_op_i[4:2] == 3'b101);
  assign shamt_s  = alu_b_i[SHAMT_W-1:0];

  // Operand sign extraction and magnitude conversion for the iterative paths
  always_comb begin
    a_sgn_s = alu_a_i[XLEN-1] && ((alu_op_i == 5'd17) || (alu_op_i == 5'd18) ||
                                  (alu_op_i == 5'd20) || (alu_op_i == 5'd22));
    b_sgn_s = alu_b_i[XLEN-1] && ((alu_op_i == 5'd17) || (alu_op_i == 5'd20) ||
                                  (alu_op_i == 5'd22));
    a_mag_s = a_sgn_s ? -alu_a_i : alu_a_i;
    b_mag_s = b_sgn_s ? -alu_b_i : alu_b_i;
  end

  // Trivial MUL/DIV operands that can skip iteration when the feature is built in
  always_comb begin
    early_s     = 1'b0;
    early_res_s = ZERO;
`ifdef ALU_MC_EARLY_OUT_EN
    if (is_mul_s && ((alu_a_i == ZERO) || (alu_b_i == ZERO))) begin
      early_s     = 1'b1;
      early_res_s = ZERO;
    end else if (is_div_s && (alu_b_i == ZERO)) begin
      early_s     = 1'b1;
      early_res_s = alu_op_i[1] ? alu_a_i : ONES;
    end else if (is_div_s && !alu_op_i[0] && (alu_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (alu_b_i == ONES)) begin
      early_s     = 1'b1;
      early_res_s = alu_op_i[1] ? ZERO : alu_a_i;
    end else begin
      early_s     = 1'b0;
    end
`endif
  end

  // Single-cycle result selection
  always_comb begin
    quick_s = ZERO;
    case (alu_op_i)
      5'd0:    quick_s = alu_a_i + alu_b_i;
      5'd1:    quick_s = alu_a_i & alu_b_i;
      5'd2:    quick_s = alu_a_i << shamt_s;
      5'd3:    quick_s = alu_a_i >> shamt_s;
      5'd4:    quick_s = alu_a_i | alu_b_i;
      5'd5:    quick_s = alu_a_i ^ alu_b_i;
      5'd6:    quick_s = ONE;
      5'd7:    quick_s = ZERO;
      5'd8:    quick_s = $signed(alu_a_i) >>> shamt_s;
      5'd9:    quick_s = alu_b_i << 4'd12;
      5'd10:   quick_s = alu_a_i - alu_b_i;
      5'd11:   quick_s = ($signed(alu_a_i) < $signed(alu_b_i)) ? ONE : ZERO;
      5'd12:   quick_s = (alu_a_i < alu_b_i) ? ONE : ZERO;
      default: quick_s = early_res_s;
    endcase
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {1'b0, ZERO});
    mul_hi_s    = mul_sum_s[XLEN:1];
    mul_lo_s    = {mul_sum_s[0], lo_r[XLEN-1:1]};
    div_shift_s = {hi_r, lo_r[XLEN-1]};
    if (div_shift_s >= {1'b0, opb_r}) begin
      div_hi_s = XLEN'(div_shift_s - {1'b0, opb_r});
      div_lo_s = {lo_r[XLEN-2:0], 1'b1};
    end else begin
      div_hi_s = div_shift_s[XLEN-1:0];
      div_lo_s = {lo_r[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and half/quotient/remainder selection at completion
  always_comb begin
    logic [2*XLEN-1:0] prod_v;
    prod_v = neg_res_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    case (op_r)
      5'd16:                fin_s = prod_v[XLEN-1:0];
      5'd17, 5'd18, 5'd19:  fin_s = prod_v[2*XLEN-1:XLEN];
      5'd20, 5'd21:         fin_s = (neg_res_r && !div0_r) ? -lo_r : lo_r;
      5'd22, 5'd23:         fin_s = neg_rem_r ? -hi_r : hi_r;
      default:              fin_s = ZERO;
    endcase
  end

  // Next-state logic; flush aborts any busy state
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && !early_s && is_mul_s)      state_s = S_MUL;
        else if (accept_s && !early_s && is_div_s) state_s = S_DIV;
        else                                       state_s = S_IDLE;
      end
      S_MUL, S_DIV: begin
        if (flush_i)                    state_s = S_IDLE;
        else if (cnt_r == CNT_W'(1))    state_s = S_FIN;
        else                            state_s = state_r;
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= ZERO;
      lo_r      <= ZERO;
      opb_r     <= ZERO;
      op_r      <= 5'd0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      result_r  <= ZERO;
      valid_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s && (is_mul_s || is_div_s) && !early_s) begin
            hi_r      <= ZERO;
            lo_r      <= a_mag_s;
            opb_r     <= b_mag_s;
            op_r      <= alu_op_i;
            neg_res_r <= a_sgn_s ^ b_sgn_s;
            neg_rem_r <= a_sgn_s;
            div0_r    <= (alu_b_i == ZERO);
            cnt_r     <= CNT_W'(XLEN);
          end else if (accept_s) begin
            result_r <= quick_s;
            valid_r  <= 1'b1;
          end
        end
        S_MUL: begin
          hi_r  <= mul_hi_s;
          lo_r  <= mul_lo_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        S_DIV: begin
          hi_r  <= div_hi_s;
          lo_r  <= div_lo_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        S_FIN: begin
          if (!flush_i) begin
            result_r <= fin_s;
            valid_r  <= 1'b1;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign alu_ready_o        = (state_r == S_IDLE);
  assign alu_busy_o         = (state_r != S_IDLE);
  assign alu_result_valid_o = valid_r;
  assign alu_result_o       = result_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32): random and directed ops against a reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, flush_i;
  logic [4:0]  alu_op_i;
  logic [31:0] alu_a_i, alu_b_i;
  logic        alu_ready_o, alu_busy_o, alu_result_valid_o;
  logic [31:0] alu_result_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_op_i(alu_op_i), .alu_a_i(alu_a_i), .alu_b_i(alu_b_i), .flush_i(flush_i),
    .alu_busy_o(alu_busy_o), .alu_result_valid_o(alu_result_valid_o),
    .alu_result_o(alu_result_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [63:0] p;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a & b;
      5'd2:  return a << b[4:0];
      5'd3:  return a >> b[4:0];
      5'd4:  return a | b;
      5'd5:  return a ^ b;
      5'd6:  return 32'd1;
      5'd7:  return 32'd0;
      5'd8:  return 32'(sa >>> b[4:0]);
      5'd9:  return b << 12;
      5'd10: return a - b;
      5'd11: return (sa < sb) ? 32'd1 : 32'd0;
      5'd12: return (a < b) ? 32'd1 : 32'd0;
      5'd16: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      5'd17: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      5'd18: begin p = longint'(sa) * {32'd0, b}; return p[63:32]; end
      5'd19: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd20: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd22: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      5'd23: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges from the accept edge to the edge that raises valid
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'd16 || op > 5'd23) return 0;
`ifdef ALU_MC_EARLY_OUT_EN
    if (op <= 5'd19 && (a == 32'd0 || b == 32'd0)) return 0;
    if (op >= 5'd20 && b == 32'd0) return 0;
    if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int rdy_low);
    @(negedge clk);
    alu_valid_i = 1'b1; alu_op_i = op; alu_a_i = a; alu_b_i = b;
    @(posedge clk); #1;
    alu_valid_i = 1'b0; alu_a_i = $urandom; alu_b_i = $urandom; alu_op_i = 5'($urandom);
    lat = 0; rdy_low = 0;
    while (!alu_result_valid_o && lat < 100) begin
      if (!alu_ready_o) rdy_low++;
      @(posedge clk); #1;
      lat++;
    end
    res = alu_result_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid_i = 1'b0; flush_i = 1'b0; alu_op_i = 5'd0; alu_a_i = 32'd0; alu_b_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({alu_ready_o, alu_busy_o, alu_result_valid_o} !== 3'b100 || alu_result_o !== 32'd0) begin
      $display("FAIL reset: rdy/busy/vld=%b%b%b result=%h, want 100 and 0", alu_ready_o, alu_busy_o, alu_result_valid_o, alu_result_o);
      n_fail++;
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    e1 = ref_alu(5'd0, 32'hFFFF_FFFF, 32'd1);
    e2 = ref_alu(5'd8, 32'h8000_0000, 32'h24);
    @(negedge clk);
    alu_valid_i = 1'b1; alu_op_i = 5'd0; alu_a_i = 32'hFFFF_FFFF; alu_b_i = 32'd1;
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_valid_o !== 1'b1 || alu_result_o !== e1) begin
      $display("FAIL b2b_add: valid=%b result=%h, want 1 %h", alu_result_valid_o, alu_result_o, e1);
      n_fail++;
    end
    @(negedge clk);
    alu_op_i = 5'd8; alu_a_i = 32'h8000_0000; alu_b_i = 32'h24;
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_valid_o !== 1'b1 || alu_result_o !== e2) begin
      $display("FAIL b2b_sra: valid=%b result=%h, want 1 %h", alu_result_valid_o, alu_result_o, e2);
      n_fail++;
    end
    @(negedge clk); alu_valid_i = 1'b0;
  endtask

  task automatic test_single_random();
    logic [31:0] a, b, res;
    logic [4:0] op;
    int lat, rl;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op >= 5'd16 && op <= 5'd23) op = op + 5'd8;
      a = pick(); b = pick();
      do_op(op, a, b, res, lat, rl);
      n_checks++;
      if (res !== ref_alu(op, a, b) || lat != 0) begin
        $display("FAIL single op=%0d a=%h b=%h: got %h lat %0d, want %h lat 0", op, a, b, res, lat, ref_alu(op, a, b));
        n_fail++;
      end
    end
  endtask

  task automatic run_multi(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    int lat, rl, el;
    el = exp_lat(op, a, b);
    do_op(op, a, b, res, lat, rl);
    n_checks++;
    if (res !== ref_alu(op, a, b) || lat != el || rl != el) begin
      $display("FAIL %s op=%0d a=%h b=%h: got %h lat %0d rdy_low %0d, want %h lat %0d rdy_low %0d",
               name, op, a, b, res, lat, rl, ref_alu(op, a, b), el, el);
      n_fail++;
    end
  endtask

  task automatic test_mul();
    run_multi("mulh_dir", 5'd17, 32'hFFFF_FFFE, 32'd3);
    run_multi("mul_dir", 5'd16, 32'hFFFF_FFFE, 32'd3);
    run_multi("mulhsu_dir", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_multi("mul_zero", 5'd19, 32'd0, 32'h1234_5678);
    for (int i = 0; i < 8; i++)
      run_multi("mul_rand", 5'(16 + $urandom_range(0, 3)), pick(), pick());
  endtask

  task automatic test_div();
    run_multi("div_dir", 5'd20, 32'hFFFF_FFF9, 32'd2);
    run_multi("rem_dir", 5'd22, 32'hFFFF_FFF9, 32'd2);
    run_multi("divu_by0", 5'd21, 32'd5, 32'd0);
    run_multi("div_by0", 5'd20, 32'hFFFF_FFF9, 32'd0);
    run_multi("rem_by0", 5'd22, 32'hFFFF_FFF9, 32'd0);
    run_multi("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF);
    run_multi("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
    run_multi("rem_neg_div", 5'd22, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 8; i++)
      run_multi("div_rand", 5'(20 + $urandom_range(0, 3)), pick(), pick());
  endtask

  task automatic test_flush();
    logic [31:0] res, held;
    int lat, rl, pulses;
    do_op(5'd0, 32'd5, 32'd6, held, lat, rl);
    @(negedge clk);
    alu_valid_i = 1'b1; alu_op_i = 5'd19; alu_a_i = 32'hFFFF_FFFF; alu_b_i = 32'hFFFF_FFFF;
    @(posedge clk); #1; alu_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (alu_ready_o !== 1'b1 || alu_busy_o !== 1'b0) begin
      $display("FAIL flush_idle: ready=%b busy=%b, want 1 0", alu_ready_o, alu_busy_o);
      n_fail++;
    end
    @(negedge clk); flush_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (alu_result_valid_o) pulses++;
    end
    n_checks++;
    if (pulses != 0 || alu_result_o !== held) begin
      $display("FAIL flush_nopulse: pulses=%0d result=%h, want 0 %h", pulses, alu_result_o, held);
      n_fail++;
    end
    do_op(5'd0, 32'd2, 32'd2, res, lat, rl);
    n_checks++;
    if (res !== 32'd4 || lat != 0) begin
      $display("FAIL flush_next_add: got %h lat %0d, want 00000004 lat 0", res, lat);
      n_fail++;
    end
    @(negedge clk);
    alu_valid_i = 1'b1; flush_i = 1'b1; alu_op_i = 5'd0; alu_a_i = 32'd7; alu_b_i = 32'd7;
    @(posedge clk); #1;
    n_checks++;
    if (alu_result_valid_o !== 1'b0 || alu_result_o !== 32'd4) begin
      $display("FAIL flush_accept: valid=%b result=%h, want 0 00000004", alu_result_valid_o, alu_result_o);
      n_fail++;
    end
    @(negedge clk); alu_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    @(negedge clk);
    alu_valid_i = 1'b1; alu_op_i = 5'd20; alu_a_i = 32'd1000; alu_b_i = 32'd7;
    @(posedge clk); #1; alu_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({alu_ready_o, alu_busy_o, alu_result_valid_o} !== 3'b100 || alu_result_o !== 32'd0) begin
      $display("FAIL reset_mid_div: rdy/busy/vld=%b%b%b result=%h, want 100 and 0", alu_ready_o, alu_busy_o, alu_result_valid_o, alu_result_o);
      n_fail++;
    end
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (alu_result_valid_o) pulses++;
    end
    n_checks++;
    if (pulses != 0 || alu_ready_o !== 1'b1) begin
      $display("FAIL reset_nopulse: pulses=%0d ready=%b, want 0 1", pulses, alu_ready_o);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_random();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
